fetch_stage: RTL

- Instruction-fetch stage of the RISC toy pipeline. It sits directly upstream of the decoder and feeds it the 32-bit INSTR word.
- Owns the PC and drives a synchronous instruction memory with fixed 1-cycle read latency.
- Holds the IF/ID pipeline register, with stall, one-entry hold buffer and branch-redirect flush.
- A flushed or empty slot presents INSTR = 32'h0, which the decoder reports as isNOP.

---
 rtl/rv_toy_pkg.sv | 9 +
 rtl/ifid_hold_buf.sv | 34 +++
 rtl/fetch_stage.sv | 107 ++++++++++
 3 files changed

// File: rtl/rv_toy_pkg.sv
// Shared constants for the RISC toy pipeline front end.
package rv_toy_pkg;

    localparam int          PC_W      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          PC_INC    = 4;

endpackage

// File: rtl/ifid_hold_buf.sv
// Single-entry buffer that parks a memory response arriving during a stall
// and replays it into IF/ID once the stall releases.
module ifid_hold_buf
    import rv_toy_pkg::*;
#(
    parameter int PC_W = rv_toy_pkg::PC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cap,
    input  logic            clr,
    input  logic [31:0]     din_instr,
    input  logic [PC_W-1:0] din_pc,
    output logic            hold_v,
    output logic [31:0]     hold_instr,
    output logic [PC_W-1:0] hold_pc
);

    // cap and clr are mutually exclusive by construction in the fetch stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v     <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc    <= '0;
        end else if (clr) begin
            hold_v <= 1'b0;
        end else if (cap) begin
            hold_v     <= 1'b1;
            hold_instr <= din_instr;
            hold_pc    <= din_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, 1-cycle synchronous IMEM request tracking and
// the IF/ID register with stall hold buffer and redirect flush.
module fetch_stage #(
    parameter int              PC_W     = rv_toy_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(rv_toy_pkg::RESET_PC)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            STALL,
    input  logic            REDIRECT,
    input  logic [PC_W-1:0] REDIRECT_PC,
    output logic            IMEM_CE,
    output logic [PC_W-1:0] IMEM_ADDR,
    input  logic [31:0]     IMEM_RDATA,
    output logic [31:0]     INSTR,
    output logic [PC_W-1:0] PC_ID,
    output logic            VALID_ID
);
    import rv_toy_pkg::*;

    logic [PC_W-1:0] pc_f;
    logic [PC_W-1:0] tgt_pc;
    logic [PC_W-1:0] pc_inc;
    logic            advance;
    logic            pend;
    logic [PC_W-1:0] pend_pc;
    logic            hold_v;
    logic [31:0]     hold_instr;
    logic [PC_W-1:0] hold_pc;
    logic            hold_cap;
    logic            hold_clr;
    logic            unused_rpc_lsb;

    assign tgt_pc         = {REDIRECT_PC[PC_W-1:2], 2'b00};
    assign unused_rpc_lsb = ^REDIRECT_PC[1:0];
    assign pc_inc         = PC_W'(PC_INC);

    // Fetch issue: a redirect always issues, even over a stall
    assign advance   = REDIRECT | ~STALL;
    assign IMEM_CE   = ~RST & advance;
    assign IMEM_ADDR = REDIRECT ? tgt_pc : pc_f;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_f <= RESET_PC;
        end else if (advance) begin
            pc_f <= IMEM_ADDR + pc_inc;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend <= 1'b0;
        end else begin
            pend <= IMEM_CE;
        end
    end

    // Address tag only; qualified by pend, so it needs no reset
    always_ff @(posedge CLK) begin
        pend_pc <= IMEM_ADDR;
    end

    assign hold_cap = ~REDIRECT & STALL & pend;
    assign hold_clr = REDIRECT | (~STALL & hold_v);

    ifid_hold_buf #(
        .PC_W (PC_W)
    ) u_hold (
        .clk        (CLK),
        .rst        (RST),
        .cap        (hold_cap),
        .clr        (hold_clr),
        .din_instr  (IMEM_RDATA),
        .din_pc     (pend_pc),
        .hold_v     (hold_v),
        .hold_instr (hold_instr),
        .hold_pc    (hold_pc)
    );

    // IF/ID register: buffered word drains before any fresh response
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            INSTR    <= NOP_INSTR;
            PC_ID    <= '0;
            VALID_ID <= 1'b0;
        end else if (REDIRECT) begin
            INSTR    <= NOP_INSTR;
            PC_ID    <= '0;
            VALID_ID <= 1'b0;
        end else if (!STALL) begin
            if (hold_v) begin
                INSTR    <= hold_instr;
                PC_ID    <= hold_pc;
                VALID_ID <= 1'b1;
            end else if (pend) begin
                INSTR    <= IMEM_RDATA;
                PC_ID    <= pend_pc;
                VALID_ID <= 1'b1;
            end else begin
                INSTR    <= NOP_INSTR;
                VALID_ID <= 1'b0;
            end
        end
    end

endmodule
